muldiv_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the EX stage, replacing the fixed 32-bit mul/div engine. It accepts one signed or unsigned multiply or divide per start/ready handshake and produces a 2×WIDTH result: {hi, lo} for multiply, {remainder, quotient} for divide. EX holds `start_i` and stalls the pipeline until `ready_o` rises. The unit adds an explicit divide-by-zero flag, a busy indicator, and an optional single-cycle multiply path.

---
 rtl/muldiv_iter_pkg.sv | 18 +
 rtl/muldiv_iter_if.sv | 25 ++
 rtl/muldiv_sign_fix.sv | 10 +
 rtl/muldiv_iter.sv | 143 ++++++++++++++
 tb/tb_muldiv_iter.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/muldiv_iter_pkg.sv
// rtl/muldiv_iter_pkg.sv - shared state codes, handshake and op encodings for muldiv_iter
package muldiv_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MIX_START            = 1'b1;
    localparam logic MIX_STOP             = 1'b0;
    localparam logic MIX_RESULT_READY     = 1'b1;
    localparam logic MIX_RESULT_NOT_READY = 1'b0;

    localparam logic MUL_OP = 1'b0;
    localparam logic DIV_OP = 1'b1;

endpackage

// File: rtl/muldiv_iter_if.sv
// rtl/muldiv_iter_if.sv - EX-stage request/result bundle for muldiv_iter
interface muldiv_iter_if #(
    parameter int WIDTH = 32
) ();
    logic                   start_i;
    logic                   annul_i;
    logic                   op_div_i;
    logic                   signed_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;
    logic                   busy_o;
    logic                   div_by_zero_o;

    modport master (
        output start_i, annul_i, op_div_i, signed_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o, div_by_zero_o
    );

    modport slave (
        input  start_i, annul_i, op_div_i, signed_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o, div_by_zero_o
    );
endinterface

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - conditional two's-complement negate
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);
    assign y = neg ? (~a + {{(W-1){1'b0}}, 1'b1}) : a;
endmodule

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative signed/unsigned multiply/divide; MULDIV_FAST_MUL_EN selects single-cycle multiply
module muldiv_iter
    import muldiv_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    muldiv_iter_if.slave   bus
);
    localparam int              CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t               state, state_d;
    logic [CW-1:0]        cnt;
    logic                 op_div_q, neg_res_q, neg_rem_q;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   result_q;
    logic                 ready_q, busy_q, dbz_q;

    logic                 neg1, neg2, accept, is_dbz;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   step;
    logic [2*WIDTH-1:0]   prod_fix, result_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign neg1   = bus.signed_i & bus.opdata1_i[WIDTH-1];
    assign neg2   = bus.signed_i & bus.opdata2_i[WIDTH-1];
    assign accept = (state == IDLE) && bus.start_i && !bus.annul_i;
    assign is_dbz = (bus.op_div_i == DIV_OP) && (bus.opdata2_i == '0);

    muldiv_sign_fix #(.W(WIDTH)) u_mag1 (.a(bus.opdata1_i), .neg(neg1), .y(mag1));
    muldiv_sign_fix #(.W(WIDTH)) u_mag2 (.a(bus.opdata2_i), .neg(neg2), .y(mag2));

    // One iteration: shift-add for multiply, restoring step for divide.
    // acc holds {hi, multiplier} for mul and {partial remainder, dividend/quotient} for div.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        div_ge    = (div_shift >= {1'b0, mag_b});
        if (op_div_q == DIV_OP)
            step = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        else
            step = {mul_sum, acc[WIDTH-1:1]};
    end

    muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (.a(step), .neg(neg_res_q), .y(prod_fix));
    muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (.a(step[WIDTH-1:0]), .neg(neg_res_q), .y(quo_fix));
    muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (.a(step[2*WIDTH-1:WIDTH]), .neg(neg_rem_q), .y(rem_fix));

    assign result_fix = (op_div_q == DIV_OP) ? {rem_fix, quo_fix} : prod_fix;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] a_ext, b_ext, fast_prod;

    // Full-width product of sign- or zero-extended operands; low 2*WIDTH bits are exact.
    always_comb begin
        a_ext     = bus.signed_i ? {{WIDTH{bus.opdata1_i[WIDTH-1]}}, bus.opdata1_i}
                                 : {{WIDTH{1'b0}}, bus.opdata1_i};
        b_ext     = bus.signed_i ? {{WIDTH{bus.opdata2_i[WIDTH-1]}}, bus.opdata2_i}
                                 : {{WIDTH{1'b0}}, bus.opdata2_i};
        fast_prod = a_ext * b_ext;
    end
`endif

    // Next-state: annul wins everywhere; DONE waits for ready to have been shown and start dropped.
    always_comb begin
        state_d = state;
        if (bus.annul_i) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i == MIX_START) begin
                        if (is_dbz)
                            state_d = DONE;
`ifdef MULDIV_FAST_MUL_EN
                        else if (bus.op_div_i == MUL_OP)
                            state_d = DONE;
`endif
                        else
                            state_d = BUSY;
                    end
                end
                BUSY:    if (cnt == LAST) state_d = DONE;
                DONE:    if (ready_q && bus.start_i == MIX_STOP) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, operand latch, iteration and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            op_div_q  <= MUL_OP;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mag_b     <= '0;
            acc       <= '0;
            result_q  <= '0;
            ready_q   <= MIX_RESULT_NOT_READY;
            busy_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state   <= state_d;
            busy_q  <= (state_d == BUSY);
            // Entering DONE straight from IDLE shows ready one cycle later.
            ready_q <= (state_d == DONE) && (state != IDLE);
            if (accept) begin
                op_div_q  <= bus.op_div_i;
                neg_res_q <= neg1 ^ neg2;
                neg_rem_q <= neg1;
                mag_b     <= (bus.op_div_i == DIV_OP) ? mag2 : mag1;
                acc       <= {{WIDTH{1'b0}}, ((bus.op_div_i == DIV_OP) ? mag1 : mag2)};
                cnt       <= '0;
                dbz_q     <= is_dbz;
                if (is_dbz)
                    result_q <= {bus.opdata1_i, {WIDTH{1'b1}}};
`ifdef MULDIV_FAST_MUL_EN
                else if (bus.op_div_i == MUL_OP)
                    result_q <= fast_prod;
`endif
            end else if (state == BUSY && !bus.annul_i) begin
                acc <= step;
                cnt <= cnt + CW'(1);
                if (cnt == LAST)
                    result_q <= result_fix;
            end
        end
    end

    assign bus.result_o      = result_q;
    assign bus.ready_o       = ready_q;
    assign bus.busy_o        = busy_q;
    assign bus.div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - directed self-checking bench for muldiv_iter (WIDTH 32 and 8)
module tb_muldiv_iter;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_EDGE = 1;
    localparam int MUL_BUSY = 0;
`else
    localparam int MUL_EDGE = 32;
    localparam int MUL_BUSY = 32;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    muldiv_iter_if #(.WIDTH(32)) if32 ();
    muldiv_iter_if #(.WIDTH(8))  if8 ();

    muldiv_iter #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    muldiv_iter #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op32(input string tag, input logic dv, input logic sg,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_res, input int exp_edge,
                           input logic exp_dbz, input int exp_busy);
        int lat;
        int nbusy;
        lat   = 0;
        nbusy = 0;
        if32.op_div_i  = dv;
        if32.signed_i  = sg;
        if32.opdata1_i = a;
        if32.opdata2_i = b;
        if32.start_i   = 1'b1;
        do begin
            tick();
            lat++;
            if (lat == 1) begin
                if32.opdata1_i = ~a;
                if32.opdata2_i = ~b;
            end
            if (if32.busy_o) nbusy++;
        end while (!if32.ready_o && lat < 200);
        check({tag, ":latency"}, 64'(lat), 64'(exp_edge + 1));
        check({tag, ":result"}, if32.result_o, exp_res);
        check({tag, ":dbz"}, 64'(if32.div_by_zero_o), 64'(exp_dbz));
        check({tag, ":busy_cycles"}, 64'(nbusy), 64'(exp_busy));
        if32.start_i = 1'b0;
        tick();
        check({tag, ":idle"}, {62'd0, if32.ready_o, if32.busy_o}, 64'd0);
    endtask

    initial begin
        int lat;
        int nbusy;
        logic saw_ready;

        if32.start_i = 0; if32.annul_i = 0; if32.op_div_i = 0; if32.signed_i = 0;
        if32.opdata1_i = '0; if32.opdata2_i = '0;
        if8.start_i = 0; if8.annul_i = 0; if8.op_div_i = 0; if8.signed_i = 0;
        if8.opdata1_i = '0; if8.opdata2_i = '0;

        #2;
        check("reset_result", if32.result_o, 64'd0);
        check("reset_ready", 64'(if32.ready_o), 64'd0);
        check("reset_busy", 64'(if32.busy_o), 64'd0);
        check("reset_dbz", 64'(if32.div_by_zero_o), 64'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        do_op32("umul_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                64'hFFFF_FFFE_0000_0001, MUL_EDGE, 1'b0, MUL_BUSY);
        do_op32("sdiv_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,
                64'hFFFF_FFFF_FFFF_FFFD, 32, 1'b0, 32);
        do_op32("div_by_zero", 1'b1, 1'b0, 32'd5, 32'd0,
                64'h0000_0005_FFFF_FFFF, 1, 1'b1, 0);
        do_op32("udiv_clears_dbz", 1'b1, 1'b0, 32'd100, 32'd7,
                64'h0000_0002_0000_000E, 32, 1'b0, 32);
        do_op32("smul_minmin", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000,
                64'h4000_0000_0000_0000, MUL_EDGE, 1'b0, MUL_BUSY);
        do_op32("smul_m3_5", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5,
                64'hFFFF_FFFF_FFFF_FFF1, MUL_EDGE, 1'b0, MUL_BUSY);
        do_op32("sdiv_7_m2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE,
                64'h0000_0001_FFFF_FFFD, 32, 1'b0, 32);

        // Annul during BUSY cycle 10, then restart immediately.
        if32.op_div_i = 1'b1; if32.signed_i = 1'b0;
        if32.opdata1_i = 32'd100; if32.opdata2_i = 32'd7;
        if32.start_i = 1'b1;
        nbusy = 0;
        saw_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if32.busy_o) nbusy++;
            if (if32.ready_o) saw_ready = 1'b1;
        end
        check("annul:busy_before", 64'(nbusy), 64'd10);
        if32.annul_i = 1'b1;
        tick();
        if (if32.ready_o) saw_ready = 1'b1;
        check("annul:busy_low", 64'(if32.busy_o), 64'd0);
        check("annul:no_ready", 64'(saw_ready), 64'd0);
        check("annul:result_kept", if32.result_o, 64'h0000_0001_FFFF_FFFD);
        if32.annul_i = 1'b0;
        do_op32("after_annul", 1'b1, 1'b0, 32'd200, 32'd7,
                64'h0000_0004_0000_001C, 32, 1'b0, 32);

        // start dropped mid-operation: completes, DONE lasts one cycle.
        if32.op_div_i = 1'b0; if32.signed_i = 1'b0;
        if32.opdata1_i = 32'd12345; if32.opdata2_i = 32'd678;
        if32.start_i = 1'b1;
        tick();
        if32.start_i = 1'b0;
        lat = 1;
        while (!if32.ready_o && lat < 200) begin
            tick();
            lat++;
        end
        check("drop_start:latency", 64'(lat), 64'(MUL_EDGE + 1));
        check("drop_start:result", if32.result_o, 64'h0000_0000_007F_B6F6);
        tick();
        check("drop_start:one_cycle", 64'(if32.ready_o), 64'd0);

        // Reset pulsed in the middle of a divide.
        if32.op_div_i = 1'b1; if32.signed_i = 1'b0;
        if32.opdata1_i = 32'd100; if32.opdata2_i = 32'd7;
        if32.start_i = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("pre_reset:busy", 64'(if32.busy_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_reset:result", if32.result_o, 64'd0);
        check("mid_reset:flags", {60'd0, if32.ready_o, if32.busy_o, if32.div_by_zero_o, 1'b0}, 64'd0);
        if32.start_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("post_reset:idle", {62'd0, if32.ready_o, if32.busy_o}, 64'd0);

        // WIDTH=8 unsigned divide 200/7 with start held in DONE.
        if8.op_div_i = 1'b1; if8.signed_i = 1'b0;
        if8.opdata1_i = 8'd200; if8.opdata2_i = 8'd7;
        if8.start_i = 1'b1;
        lat = 0;
        nbusy = 0;
        do begin
            tick();
            lat++;
            if (if8.busy_o) nbusy++;
        end while (!if8.ready_o && lat < 100);
        check("w8_div:latency", 64'(lat), 64'd9);
        check("w8_div:busy_cycles", 64'(nbusy), 64'd8);
        check("w8_div:result", 64'(if8.result_o), 64'h041C);
        for (int i = 0; i < 3; i++) tick();
        check("w8_div:held_ready", 64'(if8.ready_o), 64'd1);
        check("w8_div:held_result", 64'(if8.result_o), 64'h041C);
        if8.start_i = 1'b0;
        tick();
        check("w8_div:idle", {62'd0, if8.ready_o, if8.busy_o}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
